// File: rtl/audio_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module      : audio_sample_pacer
// Description : Single-sample holding stage between the flash reader and the
//               audio codec. Accepts one PCM sample via a valid/confirm
//               handshake and releases it, volume-scaled, on the next
//               synchronised sample-rate tick. Counts underruns.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_pacer #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int UCNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,              // asynchronous, active-low
    input  logic              sample_clk_async,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              confirm_reciv,
    input  logic              pause,
    input  logic [2:0]        vol_shift,
    output logic [DATA_W-1:0] audio_out,
    output logic              audio_strobe,
    output logic [UCNT_W-1:0] underrun_cnt
);

    typedef enum logic [1:0] {
        ST_WAIT_DATA = 2'd0,
        ST_ACK       = 2'd1,
        ST_WAIT_TICK = 2'd2
    } state_t;

    localparam logic [UCNT_W-1:0] c_UCNT_MAX = {UCNT_W{1'b1}};
    localparam logic [UCNT_W-1:0] c_UCNT_ONE = {{(UCNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   w_tick;
    logic                   w_take;

    state_t              r_state,   w_state_nxt;
    logic [DATA_W-1:0]   r_hold,    w_hold_nxt;
    logic [DATA_W-1:0]   r_audio,   w_audio_nxt;
    logic                r_confirm, w_confirm_nxt;
    logic                r_strobe,  w_strobe_nxt;
    logic [UCNT_W-1:0]   r_ucnt,    w_ucnt_nxt;

    logic signed [DATA_W-1:0] w_hold_s;
    logic        [DATA_W-1:0] w_scaled;

    // Bring the sample-rate clock into clk domain and keep the previous synchronised level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], sample_clk_async};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_tick = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    assign w_take = w_tick & ~pause;

    // Arithmetic attenuation keeps the sign of negative samples
    assign w_hold_s = r_hold;
    assign w_scaled = w_hold_s >>> vol_shift;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_WAIT_DATA;
            r_hold    <= '0;
            r_audio   <= '0;
            r_confirm <= 1'b0;
            r_strobe  <= 1'b0;
            r_ucnt    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_audio   <= w_audio_nxt;
            r_confirm <= w_confirm_nxt;
            r_strobe  <= w_strobe_nxt;
            r_ucnt    <= w_ucnt_nxt;
        end
    end

    // Next-state and next-output logic; a tick with nothing eligible to send is an underrun
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_audio_nxt   = r_audio;
        w_confirm_nxt = 1'b0;
        w_strobe_nxt  = 1'b0;
        w_ucnt_nxt    = r_ucnt;

        case (r_state)
            ST_WAIT_DATA: begin
                if (sample_valid) begin
                    w_hold_nxt    = sample_in;
                    w_confirm_nxt = 1'b1;
                    w_state_nxt   = ST_ACK;
                end
                if (w_take) begin
                    w_strobe_nxt = 1'b1;
                    if (r_ucnt != c_UCNT_MAX) begin
                        w_ucnt_nxt = r_ucnt + c_UCNT_ONE;
                    end
                end
            end
            ST_ACK: begin
                // Reader is still leaving its confirm state; its valid is stale here
                w_state_nxt = ST_WAIT_TICK;
                if (w_take) begin
                    w_strobe_nxt = 1'b1;
                    if (r_ucnt != c_UCNT_MAX) begin
                        w_ucnt_nxt = r_ucnt + c_UCNT_ONE;
                    end
                end
            end
            ST_WAIT_TICK: begin
                if (w_take) begin
                    w_audio_nxt  = w_scaled;
                    w_strobe_nxt = 1'b1;
                    w_state_nxt  = ST_WAIT_DATA;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_DATA;
            end
        endcase
    end

    assign confirm_reciv = r_confirm;
    assign audio_strobe  = r_strobe;
    assign audio_out     = r_audio;
    assign underrun_cnt  = r_ucnt;

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_pacer.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_sample_pacer
// Description : Directed self-checking bench for audio_sample_pacer with a
//               cycle-level reference model of the sample slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_sample_pacer;

    localparam int DATA_W = 16;
    localparam int SYNC   = 2;
    localparam int UCNT_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_clk_async;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              confirm_reciv;
    logic              pause;
    logic [2:0]        vol_shift;
    logic [DATA_W-1:0] audio_out;
    logic              audio_strobe;
    logic [UCNT_W-1:0] underrun_cnt;

    int errors = 0;
    int checks = 0;

    audio_sample_pacer #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC),
        .UCNT_W      (UCNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sample_clk_async (sample_clk_async),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .confirm_reciv    (confirm_reciv),
        .pause            (pause),
        .vol_shift        (vol_shift),
        .audio_out        (audio_out),
        .audio_strobe     (audio_strobe),
        .underrun_cnt     (underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one sample slot, a one-cycle cooldown after capture,
    // and a tick seen SYNC+1 clock samples after the async level rises.
    logic [7:0]        m_hist;
    logic              m_held, m_cool, m_conf, m_strb;
    logic [DATA_W-1:0] m_val, m_audio;
    logic [UCNT_W-1:0] m_cnt;

    always @(posedge clk or negedge rst) begin
        logic take, old_held, old_cool;
        logic signed [DATA_W-1:0] sv;
        if (!rst) begin
            m_hist = '0; m_held = 0; m_cool = 0; m_conf = 0; m_strb = 0;
            m_val = '0; m_audio = '0; m_cnt = '0;
        end else begin
            m_hist   = {m_hist[6:0], sample_clk_async};
            take     = m_hist[SYNC] & ~m_hist[SYNC+1] & ~pause;
            old_held = m_held;
            old_cool = m_cool;
            m_conf   = 0;
            m_strb   = 0;
            if (take) begin
                m_strb = 1;
                if (old_held && !old_cool) begin
                    sv      = m_val;
                    m_audio = sv >>> vol_shift;
                    m_held  = 0;
                end else if (m_cnt != {UCNT_W{1'b1}}) begin
                    m_cnt = m_cnt + 1'b1;
                end
            end
            if (!old_held && sample_valid) begin
                m_val  = sample_in;
                m_held = 1;
                m_cool = 1;
                m_conf = 1;
            end else if (old_cool) begin
                m_cool = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("audio_out",     audio_out,     m_audio);
        check("audio_strobe",  audio_strobe,  m_strb);
        check("confirm_reciv", confirm_reciv, m_conf);
        check("underrun_cnt",  underrun_cnt,  m_cnt);
    end

    task automatic tick();
        @(negedge clk); sample_clk_async = 1'b1;
        repeat (4) @(negedge clk);
        sample_clk_async = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic [2:0] v);
        int n;
        @(negedge clk);
        sample_in = d; vol_shift = v; sample_valid = 1'b1;
        n = 0;
        while (!confirm_reciv && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_confirm", confirm_reciv, 1'b1);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; sample_clk_async = 1'b0; sample_valid = 1'b0;
        pause = 1'b0; sample_in = '0; vol_shift = '0;
        repeat (3) @(negedge clk);
        check("rst_audio", audio_out, 16'h0000);
        check("rst_cnt", underrun_cnt, 5'd0);
        check("rst_strobe", audio_strobe, 1'b0);
        check("rst_confirm", confirm_reciv, 1'b0);
        rst = 1'b1;

        // Two underrun ticks right after reset
        tick(); tick();
        check("t2_cnt", underrun_cnt, 5'd2);
        check("t2_audio", audio_out, 16'h0000);

        // Sample out exactly three clocks after the async edge
        send(16'h1234, 3'd0);
        repeat (2) @(negedge clk);
        sample_clk_async = 1'b1;
        @(posedge clk); #1; check("t1_strobe_c1", audio_strobe, 1'b0);
        @(posedge clk); #1; check("t1_strobe_c2", audio_strobe, 1'b0);
        @(posedge clk); #1; check("t1_strobe_c3", audio_strobe, 1'b1);
        check("t1_audio", audio_out, 16'h1234);
        repeat (3) @(negedge clk);
        sample_clk_async = 1'b0;
        repeat (4) @(negedge clk);

        // Arithmetic attenuation
        send(16'h8000, 3'd7); tick();
        check("t3_neg", audio_out, 16'hFF00);
        send(16'h7FFF, 3'd3); tick();
        check("t3_pos", audio_out, 16'h0FFF);

        // Tick and valid arriving on the same clock in WAIT_DATA
        @(negedge clk); sample_clk_async = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sample_in = 16'hABCD; vol_shift = 3'd0; sample_valid = 1'b1;
        @(posedge clk); #1;
        check("t4_confirm", confirm_reciv, 1'b1);
        check("t4_strobe", audio_strobe, 1'b1);
        check("t4_audio", audio_out, 16'h0FFF);
        check("t4_cnt", underrun_cnt, 5'd3);
        @(negedge clk); sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        sample_clk_async = 1'b0;
        repeat (4) @(negedge clk);
        tick();
        check("t4_next", audio_out, 16'hABCD);

        // Pause holds the sample and drops ticks
        send(16'h5555, 3'd1);
        @(negedge clk); pause = 1'b1;
        repeat (5) tick();
        check("t5_cnt", underrun_cnt, 5'd3);
        check("t5_hold", audio_out, 16'hABCD);
        @(negedge clk); pause = 1'b0;
        tick();
        check("t5_emit", audio_out, 16'h2AAA);

        // Saturation of the underrun counter
        repeat (28) tick();
        check("t6_max", underrun_cnt, 5'd31);
        tick();
        check("t6_sat", underrun_cnt, 5'd31);

        // Asynchronous reset while a sample waits for its tick
        send(16'h1111, 3'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("t6_rst_audio", audio_out, 16'h0000);
        check("t6_rst_cnt", underrun_cnt, 5'd0);
        check("t6_rst_strobe", audio_strobe, 1'b0);
        check("t6_rst_confirm", confirm_reciv, 1'b0);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        tick();
        check("t6_discard_cnt", underrun_cnt, 5'd1);
        check("t6_discard_audio", audio_out, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
